// File: rtl/cache_miss_ctrl_if.sv
// Memory-side bus of the cache miss controller: request/response handshake to main memory.
interface cache_miss_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Miss handler between the 4-way write-back data cache and main memory.
// Writes back a dirty victim, fetches the missing word, strobes the refill
// into the cache, then lets the stalled access replay. Also keeps saturating
// miss/write-back counters and a memory-response watchdog.
module cache_miss_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic [29:0]       cpu_addr_i,
    input  logic              r_miss_i,
    input  logic              w_miss_i,
    input  logic              dirty_bit_i,
    input  logic [31:0]       wb_data_i,
    input  logic [19:0]       victim_tag_i,
    output logic              substitude_o,
    output logic [31:0]       substitude_data_o,
    output logic              cpu_stall_o,
    output logic              mem_err_o,
    output logic [CNT_W-1:0]  miss_cnt_o,
    output logic [CNT_W-1:0]  wb_cnt_o,
    cache_miss_ctrl_if.master mem
);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FETCH,
        FILL,
        REPLAY
    } state_e;

    // The watchdog expires on the edge where it would reach TIMEOUT.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [29:0]      missAddr_q, missAddr_d;
    logic [31:0]      wbData_q, wbData_d;
    logic [19:0]      victimTag_q, victimTag_d;
    logic [31:0]      fillData_q, fillData_d;
    logic [7:0]       wdog_q, wdog_d;
    logic             memErr_q, memErr_d;
    logic [CNT_W-1:0] missCnt_q, missCnt_d;
    logic [CNT_W-1:0] wbCnt_q, wbCnt_d;

    logic             missSeen;
    logic             memReq;
    logic             memWe;
    logic [29:0]      memAddr;
    logic [31:0]      memWdata;

    // A simultaneous read and write miss is a single miss.
    assign missSeen = (cpu_rd_i & r_miss_i) | (cpu_wr_i & w_miss_i);

    // State, latches, counters and watchdog; reset clears everything and overrides mem_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            missAddr_q  <= '0;
            wbData_q    <= '0;
            victimTag_q <= '0;
            fillData_q  <= '0;
            wdog_q      <= '0;
            memErr_q    <= 1'b0;
            missCnt_q   <= '0;
            wbCnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            missAddr_q  <= missAddr_d;
            wbData_q    <= wbData_d;
            victimTag_q <= victimTag_d;
            fillData_q  <= fillData_d;
            wdog_q      <= wdog_d;
            memErr_q    <= memErr_d;
            missCnt_q   <= missCnt_d;
            wbCnt_q     <= wbCnt_d;
        end
    end

    // Next-state and latch updates, plus Moore decode of the memory bus from the registered state.
    always_comb begin
        state_d     = state_q;
        missAddr_d  = missAddr_q;
        wbData_d    = wbData_q;
        victimTag_d = victimTag_q;
        fillData_d  = fillData_q;
        wdog_d      = wdog_q;
        memErr_d    = 1'b0;
        missCnt_d   = missCnt_q;
        wbCnt_d     = wbCnt_q;
        memReq      = 1'b0;
        memWe       = 1'b0;
        memAddr     = '0;
        memWdata    = '0;

        case (state_q)
            IDLE: begin
                if (missSeen) begin
                    missAddr_d  = cpu_addr_i;
                    wbData_d    = wb_data_i;
                    victimTag_d = victim_tag_i;
                    wdog_d      = '0;
                    if (missCnt_q != '1) begin
                        missCnt_d = missCnt_q + CNT_W'(1);
                    end
                    state_d = dirty_bit_i ? WB : FETCH;
                end
            end
            WB: begin
                memReq   = 1'b1;
                memWe    = 1'b1;
                memAddr  = {victimTag_q, missAddr_q[9:0]};
                memWdata = wbData_q;
                if (mem.mem_ready) begin
                    if (wbCnt_q != '1) begin
                        wbCnt_d = wbCnt_q + CNT_W'(1);
                    end
                    wdog_d  = '0;
                    state_d = FETCH;
                end else if (wdog_q == WDOG_LAST) begin
                    memErr_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            FETCH: begin
                memReq  = 1'b1;
                memAddr = missAddr_q;
                if (mem.mem_ready) begin
                    fillData_d = mem.mem_rdata;
                    state_d    = FILL;
                end else if (wdog_q == WDOG_LAST) begin
                    memErr_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            FILL: begin
                state_d = REPLAY;
            end
            REPLAY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem.mem_req   = memReq;
    assign mem.mem_we    = memWe;
    assign mem.mem_addr  = memAddr;
    assign mem.mem_wdata = memWdata;

    assign substitude_o      = (state_q == FILL);
    assign substitude_data_o = fillData_q;
    assign cpu_stall_o       = rst & ((state_q != IDLE) | missSeen);
    assign mem_err_o         = memErr_q;
    assign miss_cnt_o        = missCnt_q;
    assign wb_cnt_o          = wbCnt_q;

endmodule
